alu_muldiv: RTL
===============

# alu_muldiv

Parametrised, handshaked successor of the CPU's single-cycle integer ALU. It executes the ten base RV32I ALU operations with one-cycle latency, and the RV32M multiply/divide/remainder operations with a fixed-latency iterative datapath. It sits in the execute stage behind a valid/ready interface so the pipeline can stall on long operations.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  5  operation code (see Operation).
- a  input  XLEN  operand A (rs1).
- b  input  XLEN  operand B (rs2/immediate).
- flush  input  1  synchronous abort; drops any in-flight operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  registered result.
- busy  output  1  high in any state other than IDLE.

## Operation
- Op codes, base (single-cycle):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU.
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Shifts use b[SHW-1:0].
- Op codes, M-extension (iterative): 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU. Codes 18–31 produce result 0 with base latency.
- Operands and op are captured on the accept edge (in_valid && in_ready). Inputs are don't-care afterward.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: in_ready=1. On accept, a base/illegal op computes into result and goes to DONE. An M op loads the operand registers (magnitudes for signed forms, with sign flags saved) and a counter of 0, then goes to CALC.
  - CALC: one radix-2 step per cycle (shift-add multiply into a 2·XLEN accumulator, or restoring divide). The counter increments; after step XLEN−1, go to FIX.
  - FIX: apply sign correction. Select the low/high product half, the quotient, or the remainder. Write result, then go to DONE.
  - DONE: out_valid=1, result held stable. On out_ready, go to IDLE.
- in_ready is high only in IDLE, so there is no overlap. Base-op throughput is one per two cycles.
- MULHSU: a is signed, b is unsigned.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = a. Same fixed latency, no exception.
- Signed overflow (a = −2^(XLEN−1), b = −1): DIV returns a, REM returns 0.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- flush: in any state, next state is IDLE and out_valid is 0. A result pending in DONE is discarded. flush has priority over accept and over out_ready in the same cycle.

## Timing
- Reset (asynchronous, rst_n=0):
  - State is IDLE, so in_ready=1 and busy=0.
  - out_valid=0, result=0, counter=0, accumulators=0.
- Base op accepted at edge T: out_valid is high from T+1.
- M op accepted at edge T:
  - CALC covers T+1 … T+XLEN.
  - FIX is at T+XLEN+1.
  - out_valid is high from T+XLEN+2 (34 cycles for XLEN=32), independent of operand values.
- out_valid stays high and result stays stable until out_ready is sampled high. With out_ready tied high, DONE lasts exactly one cycle.
- Reset mid-operation: the block returns immediately to the reset values and the partial result is lost.

## Configuration
- ALU_MULDIV_EN defined: M ops (10–17) are implemented as above.
- ALU_MULDIV_EN undefined:
  - The CALC/FIX datapath and counter are not compiled.
  - Codes 10–17 behave like illegal codes: result 0, out_valid at T+1.
  - Base-op behaviour and timing are unchanged.

## Test plan
- Reset, then ADD a=0xFFFF_FFFF, b=1, out_ready=1 → out_valid at T+1, result=0x0000_0000. SRA a=0x8000_0000, b=0x24 → 0xF800_0000 (shift by 4).
- MULH a=0x8000_0000, b=0x8000_0000 → result 0x4000_0000 at exactly T+34. MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF. MUL 7×(−3) → 0xFFFF_FFEB.
- DIV/REM a=−7, b=2 → −3 / −1. DIVU a=5, b=0 → 0xFFFF_FFFF, and REMU → 5. DIV 0x8000_0000 / −1 → 0x8000_0000, and REM → 0. All at T+34.
- Backpressure: out_ready=0 for 5 cycles after out_valid → result stable and in_ready=0 throughout. A new in_valid is not accepted until the cycle after out_ready=1.
- flush asserted mid-CALC (cycle T+10) and again in DONE with out_ready=1 → next cycle IDLE, out_valid=0, the following request completes correctly. rst_n pulsed low mid-CALC → all outputs return to reset values asynchronously.
- Build without ALU_MULDIV_EN → op=10 returns 0 at T+1. Op=20 returns 0 in both builds.

Source files
------------

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Handshaked RV32I ALU with an optional iterative RV32M
//                multiply/divide datapath, enabled by defining ALU_MULDIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
`ifdef ALU_MULDIV_EN
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_base_res;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_base_res = '0;
        case (op)
            OP_ADD:  w_base_res = a + b;
            OP_SUB:  w_base_res = a - b;
            OP_SLL:  w_base_res = a << w_shamt;
            OP_SLT:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_base_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  w_base_res = a ^ b;
            OP_SRL:  w_base_res = a >> w_shamt;
            OP_SRA:  w_base_res = $signed(a) >>> w_shamt;
            OP_OR:   w_base_res = a | b;
            OP_AND:  w_base_res = a & b;
            default: w_base_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic              w_is_m;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;

    logic [4:0]        r_op;
    logic              r_neg_a;
    logic              r_neg_b;
    logic              r_bzero;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [SHW-1:0]    r_cnt;

    logic              w_is_div;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_is_m     = (op >= OP_MUL) && (op <= OP_REMU);
    assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_sa       = w_a_signed & a[XLEN-1];
    assign w_sb       = w_b_signed & b[XLEN-1];
    assign w_ma       = w_sa ? -a : a;
    assign w_mb       = w_sb ? -b : b;

    // Multiply: acc = {partial, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
    assign w_is_div  = (r_op >= OP_DIV);
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};

    always_comb begin
        w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        if (w_is_div) begin
            if (!w_diff[XLEN]) begin
                w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_acc_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end
    end

    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo  = r_bzero ? {XLEN{1'b1}}
                  : ((r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
    assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fix_res = w_quo;
            OP_REM, OP_REMU:              w_fix_res = w_rem;
            default:                      w_fix_res = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
`ifdef ALU_MULDIV_EN
            r_op      <= '0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_bzero   <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
`endif
        end else if (flush) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef ALU_MULDIV_EN
                        if (w_is_m) begin
                            r_op    <= op;
                            r_neg_a <= w_sa;
                            r_neg_b <= w_sb;
                            r_bzero <= (b == '0);
                            r_cnt   <= '0;
                            if (op >= OP_DIV) begin
                                r_opnd <= w_mb;
                                r_acc  <= {{XLEN{1'b0}}, w_ma};
                            end else begin
                                r_opnd <= w_ma;
                                r_acc  <= {{XLEN{1'b0}}, w_mb};
                            end
                            r_state <= CALC;
                        end else
`endif
                        begin
                            result    <= w_base_res;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    result    <= w_fix_res;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
